instr_decode_stage: RTL and testbench

//  Decodes raw 32-bit MIPS instruction words into the one-hot 31-command vector i[31:0] consumed by controller.

---
 rtl/instr_decode_stage.sv | 188 ++++++++++++++++++
 tb/tb_instr_decode_stage.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_decode_stage.sv
// Purpose: decodes raw 32-bit MIPS words into the controller's one-hot command vector, flags illegal words, counts deliveries.
// Latency: 1 cycle from input transfer to out_* when the output register is empty or draining.
// Backpressure: output register plus one skid entry; in_ready depends only on registered state and flush, never on out_ready.
module instr_decode_stage #(
    parameter int CNT_W        = 16,
    parameter int ILLEGAL_TRAP = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [31:0]      in_pc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_i,
    output logic [31:0]      out_instr,
    output logic [31:0]      out_pc,
    output logic             out_ill,
    output logic             halted,
    output logic [CNT_W-1:0] dec_count,
    output logic [CNT_W-1:0] ill_count
);

    typedef enum logic [0:0] {
        RUN  = 1'b0,
        HALT = 1'b1
    } state_t;

    state_t      state;
    state_t      state_nxt;

    // Skid entry: holds one word accepted while the output register was stalled.
    logic        skid_valid;
    logic [31:0] skid_instr;
    logic [31:0] skid_pc;

    logic        in_xfer;
    logic        out_xfer;
    logic        out_load;
    logic        load_valid;
    logic [31:0] load_instr;
    logic [31:0] load_pc;
    logic [32:0] load_dec;

    // Decoder: returns {illegal, one_hot[31:0]}. Only op and funct are examined.
    function automatic logic [32:0] decode(input logic [31:0] w);
        logic [31:0] v;
        v = '0;
        case (w[31:26])
            6'b000000: begin
                case (w[5:0])
                    6'b100000: v[0]  = 1'b1;  // add
                    6'b100001: v[1]  = 1'b1;  // addu
                    6'b100010: v[2]  = 1'b1;  // sub
                    6'b100011: v[3]  = 1'b1;  // subu
                    6'b100100: v[4]  = 1'b1;  // and
                    6'b100101: v[5]  = 1'b1;  // or
                    6'b100110: v[6]  = 1'b1;  // xor
                    6'b100111: v[7]  = 1'b1;  // nor
                    6'b101010: v[8]  = 1'b1;  // slt
                    6'b101011: v[9]  = 1'b1;  // sltu
                    6'b000000: v[10] = 1'b1;  // sll (also the all-zero nop)
                    6'b000010: v[11] = 1'b1;  // srl
                    6'b000011: v[12] = 1'b1;  // sra
                    6'b000100: v[13] = 1'b1;  // sllv
                    6'b000110: v[14] = 1'b1;  // srlv
                    6'b000111: v[15] = 1'b1;  // srav
                    6'b001000: v[16] = 1'b1;  // jr
                    default:   v     = '0;
                endcase
            end
            6'b001000: v[17] = 1'b1;  // addi
            6'b001001: v[18] = 1'b1;  // addiu
            6'b001100: v[19] = 1'b1;  // andi
            6'b001101: v[20] = 1'b1;  // ori
            6'b001110: v[21] = 1'b1;  // xori
            6'b100011: v[22] = 1'b1;  // lw
            6'b101011: v[23] = 1'b1;  // sw
            6'b000100: v[24] = 1'b1;  // beq
            6'b000101: v[25] = 1'b1;  // bne
            6'b001010: v[26] = 1'b1;  // slti
            6'b001011: v[27] = 1'b1;  // sltiu
            6'b001111: v[28] = 1'b1;  // lui
            6'b000010: v[29] = 1'b1;  // j
            6'b000011: v[30] = 1'b1;  // jal
            default:   v     = '0;
        endcase
        return {(v == 32'd0), v};
    endfunction

    assign in_ready = !skid_valid && (state == RUN) && !flush;
    assign in_xfer  = in_valid && in_ready;
    assign out_xfer = out_valid && out_ready;
    assign out_load = !out_valid || out_ready;
    assign halted   = (state == HALT);

    // Select the word feeding the output register: the skid entry is older, so it always goes first.
    // An input transfer implies an empty skid, so load_dec also describes the accepted input word.
    always_comb begin
        load_valid = skid_valid || in_xfer;
        load_instr = in_instr;
        load_pc    = in_pc;
        if (skid_valid) begin
            load_instr = skid_instr;
            load_pc    = skid_pc;
        end
        load_dec = decode(load_instr);
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RUN;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state: trap on accepting an illegal word; only flush (or reset) resumes.
    always_comb begin
        state_nxt = state;
        if (flush) begin
            state_nxt = RUN;
        end else if ((state == RUN) && in_xfer && load_dec[32] && (ILLEGAL_TRAP != 0)) begin
            state_nxt = HALT;
        end
    end

    // Output register: refills when empty or transferring, otherwise holds its word stable.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_i     <= '0;
            out_instr <= '0;
            out_pc    <= '0;
            out_ill   <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (out_load) begin
            out_valid <= load_valid;
            if (load_valid) begin
                out_i     <= load_dec[31:0];
                out_ill   <= load_dec[32];
                out_instr <= load_instr;
                out_pc    <= load_pc;
            end
        end
    end

    // Skid entry: captures an input word that arrives while the output register is stalled,
    // and empties whenever the output register is able to take it.
    always_ff @(posedge clk) begin
        if (rst) begin
            skid_valid <= 1'b0;
            skid_instr <= '0;
            skid_pc    <= '0;
        end else if (flush) begin
            skid_valid <= 1'b0;
        end else if (out_load) begin
            skid_valid <= 1'b0;
        end else if (in_xfer) begin
            skid_valid <= 1'b1;
            skid_instr <= in_instr;
            skid_pc    <= in_pc;
        end
    end

    // Delivery counters: saturating, bumped on every output transfer including one in a flush cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            dec_count <= '0;
            ill_count <= '0;
        end else if (out_xfer) begin
            if (out_ill) begin
                if (ill_count != {CNT_W{1'b1}}) begin
                    ill_count <= ill_count + CNT_W'(1);
                end
            end else begin
                if (dec_count != {CNT_W{1'b1}}) begin
                    dec_count <= dec_count + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_instr_decode_stage.sv
// Bench for instr_decode_stage: directed scenarios plus a randomized scoreboard run.
// Main instance traps on illegal words with 16-bit counters; second instance passes illegal words with 2-bit counters.
// All stimulus changes and output sampling happen on the falling clock edge.
module tb_instr_decode_stage;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Main instance signals
    logic        rst, flush, in_valid, in_ready, out_valid, out_ready, out_ill, halted;
    logic [31:0] in_instr, in_pc, out_i, out_instr, out_pc;
    logic [15:0] dec_count, ill_count;

    // Second instance signals
    logic        rst_s, flush_s, in_valid_s, in_ready_s, out_valid_s, out_ready_s, out_ill_s, halted_s;
    logic [31:0] in_instr_s, in_pc_s, out_i_s, out_instr_s, out_pc_s;
    logic [1:0]  dec_count_s, ill_count_s;

    instr_decode_stage #(.CNT_W(16), .ILLEGAL_TRAP(1)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_i(out_i), .out_instr(out_instr),
        .out_pc(out_pc), .out_ill(out_ill), .halted(halted),
        .dec_count(dec_count), .ill_count(ill_count)
    );

    instr_decode_stage #(.CNT_W(2), .ILLEGAL_TRAP(0)) dut_s (
        .clk(clk), .rst(rst_s), .flush(flush_s),
        .in_valid(in_valid_s), .in_ready(in_ready_s), .in_instr(in_instr_s), .in_pc(in_pc_s),
        .out_valid(out_valid_s), .out_ready(out_ready_s), .out_i(out_i_s), .out_instr(out_instr_s),
        .out_pc(out_pc_s), .out_ill(out_ill_s), .halted(halted_s),
        .dec_count(dec_count_s), .ill_count(ill_count_s)
    );

    // Command table: bit b is legal for opcode ref_op[b]; ref_fn[b][6]=1 means funct is don't-care.
    logic [5:0] ref_op [31] = '{
        6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0,
        6'b001000, 6'b001001, 6'b001100, 6'b001101, 6'b001110, 6'b100011, 6'b101011,
        6'b000100, 6'b000101, 6'b001010, 6'b001011, 6'b001111, 6'b000010, 6'b000011};
    logic [6:0] ref_fn [31] = '{
        7'b0100000, 7'b0100001, 7'b0100010, 7'b0100011, 7'b0100100, 7'b0100101, 7'b0100110, 7'b0100111,
        7'b0101010, 7'b0101011, 7'b0000000, 7'b0000010, 7'b0000011, 7'b0000100, 7'b0000110, 7'b0000111,
        7'b0001000,
        7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40};

    // Reference decode by table scan: returns {illegal, one_hot}.
    function automatic logic [32:0] model_decode(input logic [31:0] w);
        logic [31:0] v;
        v = '0;
        for (int b = 0; b < 31; b++) begin
            if (w[31:26] == ref_op[b] && (ref_fn[b][6] || w[5:0] == ref_fn[b][5:0])) v[b] = 1'b1;
        end
        return {(v == 32'd0), v};
    endfunction

    function automatic logic [31:0] gen_word();
        logic [31:0] w;
        int b;
        w = $urandom;
        if ($urandom_range(0, 9) < 8) begin
            b = $urandom_range(0, 30);
            w[31:26] = ref_op[b];
            if (!ref_fn[b][6]) w[5:0] = ref_fn[b][5:0];
        end
        return w;
    endfunction

    task automatic do_reset();
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_instr = '0; in_pc = '0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic do_reset_s();
        rst_s = 1'b1; flush_s = 1'b0; in_valid_s = 1'b0; out_ready_s = 1'b0; in_instr_s = '0; in_pc_s = '0;
        @(negedge clk);
        @(negedge clk);
        rst_s = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; flush = 1'b1; in_valid = 1'b1; out_ready = 1'b1; in_instr = 32'hFC000000; in_pc = 32'h1;
        @(negedge clk);
        @(negedge clk);
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        n_checks++; if (out_i !== 32'd0) begin n_fail++; $display("FAIL reset_out_i: got %h expected 0", out_i); end
        n_checks++; if (out_instr !== 32'd0 || out_pc !== 32'd0) begin n_fail++; $display("FAIL reset_out_instr_pc: got %h/%h expected 0/0", out_instr, out_pc); end
        n_checks++; if (out_ill !== 1'b0 || halted !== 1'b0) begin n_fail++; $display("FAIL reset_ill_halted: got %b/%b expected 0/0", out_ill, halted); end
        n_checks++; if (dec_count !== 16'd0 || ill_count !== 16'd0) begin n_fail++; $display("FAIL reset_counts: got %0d/%0d expected 0/0", dec_count, ill_count); end
        rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        #1;
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    endtask

    task automatic test_stream();
        logic [31:0] w [3];
        logic [31:0] e [3];
        w = '{32'h00221820, 32'h8C220004, 32'h08000010};
        e = '{32'h00000001, 32'h00400000, 32'h20000000};
        do_reset();
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            in_valid = 1'b1; in_instr = w[k]; in_pc = 32'h00400000 + 32'(4 * k);
            #1;
            n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL stream_in_ready[%0d]: got %b expected 1", k, in_ready); end
            @(negedge clk);
            n_checks++; if (out_valid !== 1'b1 || out_i !== e[k]) begin n_fail++; $display("FAIL stream_out_i[%0d]: got v=%b %h expected v=1 %h", k, out_valid, out_i, e[k]); end
            n_checks++; if (out_pc !== 32'h00400000 + 32'(4 * k) || out_instr !== w[k]) begin n_fail++; $display("FAIL stream_passthru[%0d]: got %h/%h expected %h/%h", k, out_pc, out_instr, 32'h00400000 + 32'(4 * k), w[k]); end
        end
        in_valid = 1'b0;
        @(negedge clk);
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL stream_drained: got %b expected 0", out_valid); end
        n_checks++; if (dec_count !== 16'd3) begin n_fail++; $display("FAIL stream_dec_count: got %0d expected 3", dec_count); end
    endtask

    task automatic test_backpressure();
        do_reset();
        out_ready = 1'b0;
        in_valid = 1'b1; in_instr = 32'h00221820; in_pc = 32'h100;
        #1;
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_ready_a: got %b expected 1", in_ready); end
        @(negedge clk);
        n_checks++; if (out_valid !== 1'b1 || out_instr !== 32'h00221820) begin n_fail++; $display("FAIL bp_out_a: got %b/%h expected 1/00221820", out_valid, out_instr); end
        in_instr = 32'h00221822; in_pc = 32'h104;
        #1;
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_ready_b: got %b expected 1", in_ready); end
        @(negedge clk);
        in_instr = 32'h20210005; in_pc = 32'h108;
        #1;
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_ready_full: got %b expected 0", in_ready); end
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            n_checks++; if (in_ready !== 1'b0 || out_instr !== 32'h00221820 || out_pc !== 32'h100) begin n_fail++; $display("FAIL bp_hold[%0d]: got rdy=%b %h/%h expected rdy=0 00221820/100", k, in_ready, out_instr, out_pc); end
        end
        out_ready = 1'b1;
        #1;
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_ready_release: got %b expected 0", in_ready); end
        @(negedge clk);
        #1;
        n_checks++; if (out_instr !== 32'h00221822 || out_i !== 32'h4 || in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_out_b: got %h i=%h rdy=%b expected 00221822 i=4 rdy=1", out_instr, out_i, in_ready); end
        @(negedge clk);
        n_checks++; if (out_instr !== 32'h20210005 || out_i !== 32'h00020000 || out_pc !== 32'h108) begin n_fail++; $display("FAIL bp_out_c: got %h i=%h pc=%h expected 20210005 i=20000 pc=108", out_instr, out_i, out_pc); end
        in_valid = 1'b0;
        @(negedge clk);
        n_checks++; if (out_valid !== 1'b0 || dec_count !== 16'd3) begin n_fail++; $display("FAIL bp_final: got v=%b cnt=%0d expected v=0 cnt=3", out_valid, dec_count); end
    endtask

    task automatic test_trap();
        do_reset();
        out_ready = 1'b1;
        in_valid = 1'b1; in_instr = 32'hFC000000; in_pc = 32'h200;
        #1;
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL trap_ready_ill: got %b expected 1", in_ready); end
        @(negedge clk);
        n_checks++; if (out_valid !== 1'b1 || out_ill !== 1'b1 || out_i !== 32'd0) begin n_fail++; $display("FAIL trap_out_ill: got v=%b ill=%b i=%h expected 1/1/0", out_valid, out_ill, out_i); end
        n_checks++; if (halted !== 1'b1) begin n_fail++; $display("FAIL trap_halted: got %b expected 1", halted); end
        in_instr = 32'h34210001; in_pc = 32'h204;
        #1;
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL trap_ready_halt: got %b expected 0", in_ready); end
        @(negedge clk);
        n_checks++; if (out_valid !== 1'b0 || ill_count !== 16'd1 || halted !== 1'b1) begin n_fail++; $display("FAIL trap_drained: got v=%b ill=%0d h=%b expected 0/1/1", out_valid, ill_count, halted); end
        flush = 1'b1;
        #1;
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL trap_ready_flush: got %b expected 0", in_ready); end
        @(negedge clk);
        flush = 1'b0;
        #1;
        n_checks++; if (halted !== 1'b0 || in_ready !== 1'b1 || out_valid !== 1'b0) begin n_fail++; $display("FAIL trap_recover: got h=%b rdy=%b v=%b expected 0/1/0", halted, in_ready, out_valid); end
        @(negedge clk);
        n_checks++; if (out_valid !== 1'b1 || out_i !== 32'h00100000 || out_ill !== 1'b0) begin n_fail++; $display("FAIL trap_ori: got v=%b i=%h ill=%b expected 1/00100000/0", out_valid, out_i, out_ill); end
        in_valid = 1'b0;
        @(negedge clk);
        n_checks++; if (dec_count !== 16'd1 || ill_count !== 16'd1) begin n_fail++; $display("FAIL trap_counts: got %0d/%0d expected 1/1", dec_count, ill_count); end
    endtask

    task automatic test_flush_full();
        do_reset();
        out_ready = 1'b0;
        in_valid = 1'b1; in_instr = 32'h00221820; in_pc = 32'h300;
        @(negedge clk);
        in_instr = 32'h00221821; in_pc = 32'h304;
        @(negedge clk);
        in_instr = 32'h00221822; in_pc = 32'h308; flush = 1'b1;
        #1;
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL flush_ready_in_cycle: got %b expected 0", in_ready); end
        @(negedge clk);
        flush = 1'b0; in_valid = 1'b0;
        #1;
        n_checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL flush_cleared: got v=%b rdy=%b expected 0/1", out_valid, in_ready); end
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_stale[%0d]: got %b expected 0", k, out_valid); end
        end
        n_checks++; if (dec_count !== 16'd0) begin n_fail++; $display("FAIL flush_dec_count: got %0d expected 0", dec_count); end
    endtask

    task automatic test_exhaustive();
        logic [31:0] w, seen;
        logic [32:0] e;
        int legal_cnt;
        legal_cnt = 0; seen = '0;
        do_reset_s();
        out_ready_s = 1'b1;
        for (int op = 0; op < 64; op++) begin
            for (int fn = 0; fn < 64; fn++) begin
                w = $urandom;
                w[31:26] = op[5:0];
                w[5:0] = fn[5:0];
                if (op == 0 && fn == 0) w = 32'd0;
                in_valid_s = 1'b1; in_instr_s = w; in_pc_s = w ^ 32'hA5A5_5A5A;
                #1;
                n_checks++; if (in_ready_s !== 1'b1) begin n_fail++; $display("FAIL exh_ready[%h]: got %b expected 1", w, in_ready_s); end
                @(negedge clk);
                e = model_decode(w);
                n_checks++; if (out_valid_s !== 1'b1 || out_i_s !== e[31:0] || out_ill_s !== e[32]) begin n_fail++; $display("FAIL exh_decode[%h]: got v=%b i=%h ill=%b expected v=1 i=%h ill=%b", w, out_valid_s, out_i_s, out_ill_s, e[31:0], e[32]); end
                if (out_ill_s === 1'b0) begin
                    legal_cnt++;
                    n_checks++; if ($countones(out_i_s) != 1) begin n_fail++; $display("FAIL exh_onehot[%h]: got %h expected one bit", w, out_i_s); end
                end
                if (w == 32'd0) begin
                    n_checks++; if (out_i_s !== 32'h00000400) begin n_fail++; $display("FAIL exh_zero_word: got %h expected 00000400", out_i_s); end
                end
                seen = seen | out_i_s;
            end
        end
        in_valid_s = 1'b0;
        @(negedge clk);
        n_checks++; if (legal_cnt != 913) begin n_fail++; $display("FAIL exh_legal_count: got %0d expected 913", legal_cnt); end
        n_checks++; if (seen !== 32'h7FFFFFFF) begin n_fail++; $display("FAIL exh_bits_seen: got %h expected 7fffffff", seen); end
    endtask

    task automatic test_saturate_and_reset();
        int sent, ev;
        do_reset_s();
        out_ready_s = 1'b1;
        for (int k = 0; k < 7; k++) begin
            sent = (k - 1 < 0) ? 0 : ((k - 1 > 5) ? 5 : k - 1);
            ev = (sent > 3) ? 3 : sent;
            n_checks++; if (dec_count_s !== 2'(ev)) begin n_fail++; $display("FAIL sat_dec_count[%0d]: got %0d expected %0d", k, dec_count_s, ev); end
            in_valid_s = (k < 5); in_instr_s = 32'h00221820 + 32'(k << 11); in_pc_s = 32'h400 + 32'(4 * k);
            @(negedge clk);
        end
        out_ready_s = 1'b0;
        in_valid_s = 1'b1; in_instr_s = 32'h8C220004; in_pc_s = 32'h500;
        @(negedge clk);
        in_instr_s = 32'hAC220004; in_pc_s = 32'h504;
        @(negedge clk);
        in_instr_s = 32'h10220004; in_pc_s = 32'h508; rst_s = 1'b1;
        @(negedge clk);
        n_checks++; if (out_valid_s !== 1'b0 || out_i_s !== 32'd0 || out_ill_s !== 1'b0 || halted_s !== 1'b0) begin n_fail++; $display("FAIL midrst_flags: got v=%b i=%h ill=%b h=%b expected 0/0/0/0", out_valid_s, out_i_s, out_ill_s, halted_s); end
        n_checks++; if (out_instr_s !== 32'd0 || out_pc_s !== 32'd0 || dec_count_s !== 2'd0 || ill_count_s !== 2'd0) begin n_fail++; $display("FAIL midrst_data: got %h/%h %0d/%0d expected 0/0 0/0", out_instr_s, out_pc_s, dec_count_s, ill_count_s); end
        rst_s = 1'b0; in_valid_s = 1'b0; out_ready_s = 1'b1;
        #1;
        n_checks++; if (in_ready_s !== 1'b1) begin n_fail++; $display("FAIL midrst_ready: got %b expected 1", in_ready_s); end
        @(negedge clk);
        n_checks++; if (out_valid_s !== 1'b0) begin n_fail++; $display("FAIL midrst_stale: got %b expected 0", out_valid_s); end
    endtask

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } item_t;

    // Randomized run: queue of buffered words models the stage; halt and counters tracked separately.
    task automatic test_random(input int n);
        item_t q[$];
        item_t it;
        logic [32:0] e;
        logic halted_m, exp_rdy;
        int dec_m, ill_m;
        q.delete(); halted_m = 1'b0; dec_m = 0; ill_m = 0;
        do_reset();
        for (int c = 0; c < n; c++) begin
            n_checks++; if (out_valid !== (q.size() > 0)) begin n_fail++; $display("FAIL rnd_out_valid[%0d]: got %b expected %b", c, out_valid, q.size() > 0); end
            if (q.size() > 0) begin
                e = model_decode(q[0].instr);
                n_checks++; if (out_instr !== q[0].instr || out_pc !== q[0].pc || out_i !== e[31:0] || out_ill !== e[32]) begin n_fail++; $display("FAIL rnd_out[%0d]: got %h/%h i=%h ill=%b expected %h/%h i=%h ill=%b", c, out_instr, out_pc, out_i, out_ill, q[0].instr, q[0].pc, e[31:0], e[32]); end
            end
            n_checks++; if (halted !== halted_m || dec_count !== 16'(dec_m) || ill_count !== 16'(ill_m)) begin n_fail++; $display("FAIL rnd_state[%0d]: got h=%b %0d/%0d expected h=%b %0d/%0d", c, halted, dec_count, ill_count, halted_m, dec_m, ill_m); end
            flush = (halted_m && q.size() == 0) || ($urandom_range(0, 49) == 0);
            out_ready = ($urandom_range(0, 3) != 0);
            in_valid = ($urandom_range(0, 3) != 0);
            in_instr = gen_word();
            in_pc = $urandom;
            #1;
            exp_rdy = (q.size() < 2) && !halted_m && !flush;
            n_checks++; if (in_ready !== exp_rdy) begin n_fail++; $display("FAIL rnd_in_ready[%0d]: got %b expected %b", c, in_ready, exp_rdy); end
            if (q.size() > 0 && out_ready) begin
                it = q.pop_front();
                e = model_decode(it.instr);
                if (e[32]) ill_m++; else dec_m++;
            end
            if (flush) begin
                q.delete();
                halted_m = 1'b0;
            end else if (in_valid && exp_rdy) begin
                q.push_back('{instr: in_instr, pc: in_pc});
                e = model_decode(in_instr);
                if (e[32]) halted_m = 1'b1;
            end
            @(negedge clk);
        end
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_s = 1'b1; flush_s = 1'b0; in_valid_s = 1'b0; out_ready_s = 1'b0; in_instr_s = '0; in_pc_s = '0;
        test_reset();
        test_stream();
        test_backpressure();
        test_trap();
        test_flush_full();
        test_random(800);
        test_exhaustive();
        test_saturate_and_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
